// File: rtl/lcd_mem_pkg.sv
// lcd_mem_pkg: shared widths and size helpers for the LCD byte FIFO and its RAM.
package lcd_mem_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/ram_fifo_if.sv
// ram_fifo_if: producer/consumer handshake bundle of the FIFO; error flags exist only with RAM_FIFO_ERR_EN.
interface ram_fifo_if
    import lcd_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic                       rd_en;
    logic [DATA_W-1:0]          rd_data;
    logic                       rd_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic [cnt_w(ADDR_W)-1:0]   count;
`ifdef RAM_FIFO_ERR_EN
    logic                       err_clr;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
`else
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, count
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, count
    );
`endif
endinterface

// File: rtl/ram_fifo_dp.sv
// ram_dp: simple dual-port RAM, one write port, one read port with registered address; storage not reset.
module ram_dp
    import lcd_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [depth(ADDR_W)];
    logic [ADDR_W-1:0] raddr_q;

    // write port: store on we
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // read port: latch the address so data appears the cycle after the request
    always_ff @(posedge clk)
        if (re) raddr_q <= raddr;

    assign rdata = mem[raddr_q];
endmodule

// File: rtl/ram_fifo.sv
// ram_fifo: synchronous FIFO over ram_dp with count, full/empty/almost_full; sticky overflow/underflow when RAM_FIFO_ERR_EN is defined.
module ram_fifo
    import lcd_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AFULL_TH = 12
) (
    input  logic       clk,
    input  logic       rst,
    ram_fifo_if.slave  bus
);
    localparam int DEPTH = depth(ADDR_W);
    localparam int CW    = cnt_w(ADDR_W);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              full_q, empty_q, afull_q, rd_valid_q;
    logic [DATA_W-1:0] ram_q, hold_q;
    logic              wr_acc, rd_acc;

    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    ram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // next occupancy; flags are registered from it so they move with count
    always_comb cnt_nxt = cnt + CW'(wr_acc) - CW'(rd_acc);

    // pointers, occupancy, flags and read-valid pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt        <= cnt_nxt;
            full_q     <= cnt_nxt == CW'(DEPTH);
            empty_q    <= cnt_nxt == '0;
            afull_q    <= cnt_nxt >= CW'(AFULL_TH);
            rd_valid_q <= rd_acc;
        end

    // keep the last delivered word so rd_data holds between reads
    always_ff @(posedge clk or posedge rst)
        if (rst) hold_q <= '0;
        else if (rd_valid_q) hold_q <= ram_q;

    assign bus.rd_data     = rd_valid_q ? ram_q : hold_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = cnt;

`ifdef RAM_FIFO_ERR_EN
    logic ovf_q, unf_q;

    // sticky error flags; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (bus.wr_en & full_q) | (ovf_q & ~bus.err_clr);
            unf_q <= (bus.rd_en & empty_q) | (unf_q & ~bus.err_clr);
        end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo: vector table, directed corner sequences and random traffic against a queue model of the FIFO.
module tb_ram_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    ram_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    ram_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        int         cnt;
        logic       v;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all();
        check("count", 32'(bus.count), 32'(q.size()));
        check("full", 32'(bus.full), 32'(q.size() == 16));
        check("empty", 32'(bus.empty), 32'(q.size() == 0));
        check("almost_full", 32'(bus.almost_full), 32'(q.size() >= 12));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check("rd_data", 32'(bus.rd_data), 32'(m_data));
`ifdef RAM_FIFO_ERR_EN
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        int sz;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.wr_data = d;
`ifdef RAM_FIFO_ERR_EN
        bus.err_clr = clr;
`endif
        @(posedge clk);
        #1;
        sz    = q.size();
        m_ovf = (w && sz == 16) || (m_ovf && !clr);
        m_unf = (r && sz == 0) || (m_unf && !clr);
        m_valid = r && sz > 0;
        if (m_valid) m_data = q.pop_front();
        if (w && sz < 16) q.push_back(d);
        check_all();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1, 1, 8'h55, 1, 0, 8'h00};
        tbl[1] = '{0, 1, 8'h00, 0, 1, 8'h55};
        tbl[2] = '{0, 1, 8'h00, 0, 0, 8'h55};
        tbl[3] = '{1, 0, 8'h11, 1, 0, 8'h55};
        tbl[4] = '{1, 0, 8'h22, 2, 0, 8'h55};
        tbl[5] = '{1, 1, 8'h33, 2, 1, 8'h11};
        tbl[6] = '{0, 1, 8'h00, 1, 1, 8'h22};
        tbl[7] = '{0, 1, 8'h00, 0, 1, 8'h33};
        tbl[8] = '{0, 1, 8'h00, 0, 0, 8'h33};

        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = 8'h00;
`ifdef RAM_FIFO_ERR_EN
        bus.err_clr = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d);
            check("tbl_count", 32'(bus.count), 32'(tbl[i].cnt));
            check("tbl_valid", 32'(bus.rd_valid), 32'(tbl[i].v));
            check("tbl_data", 32'(bus.rd_data), 32'(tbl[i].rd));
        end

`ifdef RAM_FIFO_ERR_EN
        clr = 1'b1;
        step(0, 1, 8'h00);
        check("underflow_set_wins", 32'(bus.underflow), 32'd1);
        step(0, 0, 8'h00);
        check("underflow_cleared", 32'(bus.underflow), 32'd0);
        clr = 1'b0;
`endif

        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i));
            if (i == 11) check("afull_at_12", 32'(bus.almost_full), 32'd1);
        end
        check("full_at_16", 32'(bus.full), 32'd1);
        step(1, 0, 8'hEE);
`ifdef RAM_FIFO_ERR_EN
        check("overflow_sticky", 32'(bus.overflow), 32'd1);
`endif
        step(1, 1, 8'hEE);
        check("full_both_head", 32'(bus.rd_data), 32'h00);
        check("full_both_count", 32'(bus.count), 32'd15);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 8'h00);
            check("drain_order", 32'(bus.rd_data), 32'(i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
`ifdef RAM_FIFO_ERR_EN
        clr = 1'b1;
        step(0, 0, 8'h00);
        clr = 1'b0;
        check("overflow_cleared", 32'(bus.overflow), 32'd0);
`endif

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) step(1, 0, 8'hA0 + 8'(i));
            for (int i = 0; i < 10; i++) begin
                step(0, 1, 8'h00);
                check("wrap_data", 32'(bus.rd_data), 32'(8'hA0 + 8'(i)));
            end
        end
        check("wrap_count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 8; i++) step(1, 0, 8'h40 + 8'(i));
        step(1, 1, 8'h77);
        check("half_both_count", 32'(bus.count), 32'd8);
        check("half_both_data", 32'(bus.rd_data), 32'h40);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00);

        step(0, 1, 8'h00);
        check("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
        check("pre_rst_count", 32'(bus.count), 32'd4);
        step(1, 0, 8'h90);
        step(0, 1, 8'h00);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 1, 8'h00);
        check("post_rst_no_valid", 32'(bus.rd_valid), 32'd0);

        for (int ph = 0; ph < 10; ph++) begin
            int pw;
            int pr;
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 300; i++) begin
                clr = ($urandom_range(0, 19) == 0);
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
            end
        end
        clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
